// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the bit-counter width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index bits 0..width-1 and stay at least one bit wide.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a registered carry,
// LSB first, with valid/ready handshakes on operands and result.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              fa_s, fa_co;

    fa_cell u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                carry_d          = fa_co;
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB for this final bit.
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1: arithmetic,
// latency, backpressure, asynchronous reset and back-to-back throughput.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Arithmetic reference: whole-word addition, not a bit-serial walk.
    task automatic ref8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                        output logic [7:0] s, output logic c, output logic o);
        logic [8:0] full;
        logic [7:0] low;
        logic [7:0] bb;
        logic       ci;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
        low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, ci};
        s    = full[7:0];
        c    = full[8];
        o    = low[7] ^ full[8];
    endtask

    // Accept one operation on the 8-bit DUT and wait for its result; out_ready is
    // left low so the caller decides when to release it. Runs at posedge+1 phase.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output int lat);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || busy8 !== 1'b0 ||
            sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state8: rdy=%b ov=%b busy=%b sum=%h cout=%b ovf=%b, required 0 0 0 00 0 0",
                     in_ready8, out_valid8, busy8, sum8, cout8, ovf8);
        end
        checks++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || busy1 !== 1'b0 || sum1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state1: rdy=%b ov=%b busy=%b sum=%b, required all 0",
                     in_ready1, out_valid1, busy1, sum1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: rdy8=%b rdy1=%b, required 1 1", in_ready8, in_ready1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width1();
        logic [2:0] vin  [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
        logic [2:0] vexp [4] = '{3'b000, 3'b101, 3'b010, 3'b110};
        for (int i = 0; i < 4; i++) begin
            int lat;
            a1 = vin[i][2]; b1 = vin[i][1]; cin1 = vin[i][0]; sub1 = 1'b0; in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL w1_latency[%0d]: got %0d clocks, required 1", i, lat);
            end
            checks++;
            if ({sum1, cout1, ovf1} !== vexp[i]) begin
                errors++;
                $display("FAIL w1_result[%0d]: sum,cout,ovf=%b%b%b required %b", i, sum1, cout1, ovf1, vexp[i]);
            end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end
    endtask

    task automatic test_ops8();
        logic [7:0] va  [5] = '{8'hFF, 8'h7F, 8'h3C, 8'h05, 8'h80};
        logic [7:0] vb  [5] = '{8'h01, 8'h01, 8'h41, 8'h07, 8'h01};
        logic       vc  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       vsb [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0] vex [5] = '{{8'h00, 2'b10}, {8'h80, 2'b01}, {8'h7E, 2'b00},
                                {8'hFE, 2'b00}, {8'h7F, 2'b11}};
        for (int i = 0; i < 5; i++) begin
            int lat;
            start8(va[i], vb[i], vc[i], vsb[i], lat);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL w8_latency[%0d]: got %0d clocks, required 8", i, lat);
            end
            checks++;
            if ({sum8, cout8, ovf8} !== vex[i]) begin
                errors++;
                $display("FAIL w8_result[%0d]: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                         i, sum8, cout8, ovf8, vex[i][9:2], vex[i][1], vex[i][0]);
            end
            release8();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] s0;
        logic       c0, o0;
        start8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        s0 = 8'h80; c0 = 1'b0; o0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1; in_valid8 = (k == 2);
            @(posedge clk); #1;
            checks++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== s0 || cout8 !== c0 || ovf8 !== o0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: ov=%b rdy=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                         k, out_valid8, in_ready8, sum8, cout8, ovf8, s0, c0, o0);
            end
        end
        in_valid8 = 1'b0;
        release8();
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== s0) begin
            errors++;
            $display("FAIL backpressure_release: ov=%b rdy=%b busy=%b sum=%h required 0 1 0 %h",
                     out_valid8, in_ready8, busy8, sum8, s0);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        // Leave cout=1 from the previous result so the reset clear is visible.
        start8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        release8();
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy8 !== 1'b1 || sum8 === 8'h00) begin
            errors++;
            $display("FAIL midrun_before_reset: busy=%b sum=%h required busy=1 sum nonzero", busy8, sum8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0 ||
            ovf8 !== 1'b0 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async_reset: ov=%b busy=%b sum=%h cout=%b ovf=%b rdy=%b required all 0",
                     out_valid8, busy8, sum8, cout8, ovf8, in_ready8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start8(8'h01, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 8 || sum8 !== 8'h02 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: lat=%0d sum=%h cout=%b ovf=%b required 8 02 0 0",
                     lat, sum8, cout8, ovf8);
        end
        release8();
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [100];
        logic [7:0] vb [100];
        logic       vc [100];
        logic       vs [100];
        int cyc = 0, last_acc = -1, issued = 0, got = 0;
        for (int i = 0; i < 100; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(0, 255));
            vc[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
        end
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        a8 = va[0]; b8 = vb[0]; cin8 = vc[0]; sub8 = vs[0];
        while (got < 100 && cyc < 3000) begin
            logic acc;
            acc = in_ready8 && in_valid8;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 10) begin
                        errors++;
                        $display("FAIL b2b_interval[%0d]: got %0d clocks, required 10", issued, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                issued++;
                if (issued < 100) begin
                    a8 = va[issued]; b8 = vb[issued]; cin8 = vc[issued]; sub8 = vs[issued];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
            if (out_valid8) begin
                logic [7:0] es;
                logic       ec, eo;
                ref8(va[got], vb[got], vc[got], vs[got], es, ec, eo);
                checks++;
                if (sum8 !== es || cout8 !== ec || ovf8 !== eo) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b required %h %b %b",
                             got, va[got], vb[got], vc[got], vs[got], sum8, cout8, ovf8, es, ec, eo);
                end
                got++;
            end
        end
        checks++;
        if (got !== 100) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results, required 100", got);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        test_reset();
        test_width1();
        test_ops8();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
